// File: rtl/intr_ctrl.sv
// intr_ctrl: vectored interrupt controller with edge-latched pending bits,
// a mask register, fixed-priority arbitration (line 0 highest) and a Moore
// sequencer that drives the return-address stack and the PC load controls.
module intr_ctrl #(
    parameter logic [9:0]  VEC_BASE = 10'd1000,
    parameter int unsigned NIRQ     = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NIRQ-1:0] irq,
    input  logic            mask_we,
    input  logic [NIRQ-1:0] mask_in,
    input  logic            boundary,
    input  logic            reti,
    output logic            stack_push,
    output logic            stack_pop,
    output logic            s_intr,
    output logic            ret_load,
    output logic            vec_load,
    output logic [9:0]      vector,
    output logic            in_service,
    output logic [NIRQ-1:0] pending,
    output logic [NIRQ-1:0] mask
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SAVE,
        ST_JUMP,
        ST_ISR,
        ST_RET
    } state_t;

    state_t          state_q, state_d;
    logic [NIRQ-1:0] irq_q, irq_d;
    logic [NIRQ-1:0] pending_q, pending_d;
    logic [NIRQ-1:0] mask_q, mask_d;
    logic [1:0]      idx_q, idx_d;

    logic            stack_push_q, stack_push_d;
    logic            ret_phase_q, ret_phase_d;
    logic            vec_load_q, vec_load_d;
    logic            in_service_q, in_service_d;
    logic [9:0]      vector_q, vector_d;

    logic [NIRQ-1:0] req;
    logic [NIRQ-1:0] clr;
    logic [1:0]      sel;

    // Next-state, edge detection, arbitration and output decode.
    // Outputs are registered from the next state so they still depend on state only.
    always_comb begin
        state_d = state_q;
        irq_d   = irq;
        mask_d  = mask_we ? mask_in : mask_q;
        idx_d   = idx_q;
        clr     = '0;
        req     = pending_q & mask_q;

        sel = '0;
        for (int unsigned i = NIRQ; i > 0; i--) begin
            if (req[i-1]) begin
                sel = 2'(i - 1);
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (boundary && (req != '0)) begin
                    state_d  = ST_SAVE;
                    idx_d    = sel;
                    clr[sel] = 1'b1;
                end
            end
            ST_SAVE: state_d = ST_JUMP;
            ST_JUMP: state_d = ST_ISR;
            ST_ISR: begin
                if (reti) begin
                    state_d = ST_RET;
                end
            end
            ST_RET:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // A fresh edge re-sets a bit being cleared by service in the same cycle.
        pending_d = (pending_q & ~clr) | (irq & ~irq_q);

        stack_push_d = (state_d == ST_SAVE);
        vec_load_d   = (state_d == ST_JUMP);
        in_service_d = (state_d == ST_ISR);
        ret_phase_d  = (state_d == ST_RET);
        vector_d     = VEC_BASE + 10'({idx_d, 2'b00});
    end

    // State and registered outputs; reset aborts any sequence immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            irq_q        <= '0;
            pending_q    <= '0;
            mask_q       <= '0;
            idx_q        <= '0;
            stack_push_q <= 1'b0;
            ret_phase_q  <= 1'b0;
            vec_load_q   <= 1'b0;
            in_service_q <= 1'b0;
            vector_q     <= VEC_BASE;
        end else begin
            state_q      <= state_d;
            irq_q        <= irq_d;
            pending_q    <= pending_d;
            mask_q       <= mask_d;
            idx_q        <= idx_d;
            stack_push_q <= stack_push_d;
            ret_phase_q  <= ret_phase_d;
            vec_load_q   <= vec_load_d;
            in_service_q <= in_service_d;
            vector_q     <= vector_d;
        end
    end

    assign stack_push = stack_push_q;
    assign stack_pop  = ret_phase_q;
    assign s_intr     = ret_phase_q;
    assign ret_load   = ret_phase_q;
    assign vec_load   = vec_load_q;
    assign in_service = in_service_q;
    assign vector     = vector_q;
    assign pending    = pending_q;
    assign mask       = mask_q;

endmodule
